// File: rtl/sat_pkg.sv
// Shared SAT-engine package: default widths used across the engine slice,
// the beat-kind encoding used on the bin store stream and the unload FSM
// state type, plus a small width helper.
package sat_pkg;

    localparam int DEF_NUM_CLAUSES      = 8;
    localparam int DEF_NUM_VARS         = 8;
    localparam int DEF_NUM_LVLS         = 8;
    localparam int DEF_WIDTH_BIN_ID     = 10;
    localparam int DEF_WIDTH_VAR_STATES = 19;
    localparam int DEF_WIDTH_LVL_STATES = 11;

    // Entry index carried on every beat; every list is at most 256 long.
    localparam int WIDTH_IDX = 8;

    typedef enum logic [1:0] {
        KIND_CLAUSE = 2'd0,
        KIND_VAR    = 2'd1,
        KIND_LVL    = 2'd2,
        KIND_RSVD   = 2'd3
    } beat_kind_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_C   = 3'd1,
        CAP_C  = 3'd2,
        SEND_C = 3'd3,
        SEND_V = 3'd4,
        SEND_L = 3'd5,
        FIN    = 3'd6
    } wb_state_e;

    // Largest of three widths, used to size a shared payload bus.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/bin_wb_out_reg.sv
// Single-entry valid/ready holding register. Once a beat is loaded, its
// fields stay frozen until the sink accepts it, and valid is purely a
// register so it never depends combinationally on ready. The loader must
// only load while the register is empty or is being drained this cycle.
module bin_wb_out_reg #(
    parameter int WIDTH_BIN  = 10,
    parameter int WIDTH_IDX  = 8,
    parameter int WIDTH_DATA = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [1:0]            kind_i,
    input  logic [WIDTH_BIN-1:0]  bin_i,
    input  logic [WIDTH_IDX-1:0]  idx_i,
    input  logic [WIDTH_DATA-1:0] data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic                  fire_o,
    output logic [1:0]            kind_o,
    output logic [WIDTH_BIN-1:0]  bin_o,
    output logic [WIDTH_IDX-1:0]  idx_o,
    output logic [WIDTH_DATA-1:0] data_o
);

    logic                  valid_q, valid_d;
    logic [1:0]            kind_q, kind_d;
    logic [WIDTH_BIN-1:0]  bin_q, bin_d;
    logic [WIDTH_IDX-1:0]  idx_q, idx_d;
    logic [WIDTH_DATA-1:0] data_q, data_d;

    // Next entry: a new load wins, otherwise an accepted beat empties the
    // register and clears its fields so an idle bus reads as zero.
    always_comb begin
        valid_d = valid_q;
        kind_d  = kind_q;
        bin_d   = bin_q;
        idx_d   = idx_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            kind_d  = kind_i;
            bin_d   = bin_i;
            idx_d   = idx_i;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
            kind_d  = '0;
            bin_d   = '0;
            idx_d   = '0;
            data_d  = '0;
        end
    end

    // Entry storage, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            kind_q  <= '0;
            bin_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            kind_q  <= kind_d;
            bin_q   <= bin_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign fire_o  = valid_q & ready_i;
    assign kind_o  = kind_q;
    assign bin_o   = bin_q;
    assign idx_o   = idx_q;
    assign data_o  = data_q;

endmodule

// File: rtl/bin_writeback.sv
// Bin unload engine. On start it snapshots the engine's variable and level
// state lists, then walks the clause array one slot at a time (select,
// capture, send) and finally streams the snapshot lists, every entry as a
// tagged beat on a valid/ready bus towards the bin store.
// Optional feature macro BIN_WB_SKIP_EMPTY_EN: when defined, all-zero
// clauses are dropped from the stream at capture time instead of sent.
module bin_writeback
    import sat_pkg::*;
#(
    parameter int NUM_CLAUSES      = DEF_NUM_CLAUSES,
    parameter int NUM_VARS         = DEF_NUM_VARS,
    parameter int NUM_LVLS         = DEF_NUM_LVLS,
    parameter int WIDTH_BIN_ID     = DEF_WIDTH_BIN_ID,
    parameter int WIDTH_VAR_STATES = DEF_WIDTH_VAR_STATES,
    parameter int WIDTH_LVL_STATES = DEF_WIDTH_LVL_STATES,
    localparam int WIDTH_DATA      = max3(NUM_VARS * 3, WIDTH_VAR_STATES, WIDTH_LVL_STATES)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_i,
    input  logic [WIDTH_BIN_ID-1:0]              bin_id_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [NUM_CLAUSES-1:0]               rd_carray_o,
    input  logic [NUM_VARS*3-1:0]                clause_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [1:0]                           out_kind_o,
    output logic [WIDTH_BIN_ID-1:0]              out_bin_o,
    output logic [WIDTH_IDX-1:0]                 out_idx_o,
    output logic [WIDTH_DATA-1:0]                out_data_o
);

    localparam int WIDTH_CLAUSE = NUM_VARS * 3;

    localparam logic [WIDTH_IDX-1:0]   LAST_C  = WIDTH_IDX'(NUM_CLAUSES - 1);
    localparam logic [WIDTH_IDX-1:0]   LAST_V  = WIDTH_IDX'(NUM_VARS - 1);
    localparam logic [WIDTH_IDX-1:0]   LAST_L  = WIDTH_IDX'(NUM_LVLS - 1);
    localparam logic [NUM_CLAUSES-1:0] ONE_SEL = NUM_CLAUSES'(1);

    wb_state_e                            state_q, state_d;
    logic [WIDTH_IDX-1:0]                 idx_q, idx_d;
    logic [WIDTH_BIN_ID-1:0]              bin_q, bin_d;
    logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_q, vars_d;
    logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvls_q, lvls_d;
    logic                                 busy_q, busy_d;
    logic                                 done_q, done_d;
    logic [NUM_CLAUSES-1:0]               rd_carray_q, rd_carray_d;

    logic                                 beatLoad;
    beat_kind_e                           beatKind;
    logic [WIDTH_DATA-1:0]                beatData;
    logic                                 beatFire;

    // Sequencing decisions. A beat is loaded into the holding register on
    // the same edge that enters its send state, so the first cycle of every
    // send state already presents a valid beat and state beats can go back
    // to back under continuous ready.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bin_d    = bin_q;
        vars_d   = vars_q;
        lvls_d   = lvls_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        beatLoad = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    bin_d   = bin_id_i;
                    vars_d  = vars_states_i;
                    lvls_d  = lvl_states_i;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RD_C;
                end
            end
            RD_C: begin
                state_d = CAP_C;
            end
            CAP_C: begin
`ifdef BIN_WB_SKIP_EMPTY_EN
                if (clause_i == '0) begin
                    if (idx_q == LAST_C) begin
                        idx_d    = '0;
                        state_d  = SEND_V;
                        beatLoad = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = RD_C;
                    end
                end else begin
                    state_d  = SEND_C;
                    beatLoad = 1'b1;
                end
`else
                state_d  = SEND_C;
                beatLoad = 1'b1;
`endif
            end
            SEND_C: begin
                if (beatFire) begin
                    if (idx_q == LAST_C) begin
                        idx_d    = '0;
                        state_d  = SEND_V;
                        beatLoad = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = RD_C;
                    end
                end
            end
            SEND_V: begin
                if (beatFire) begin
                    beatLoad = 1'b1;
                    if (idx_q == LAST_V) begin
                        idx_d   = '0;
                        state_d = SEND_L;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SEND_L: begin
                if (beatFire) begin
                    if (idx_q == LAST_L) begin
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        beatLoad = 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Payload of the beat being loaded, chosen by the state it is sent in
    // and the index it will carry; narrower entries are zero-extended.
    always_comb begin
        beatKind = KIND_CLAUSE;
        beatData = '0;
        case (state_d)
            SEND_V: begin
                beatKind = KIND_VAR;
                beatData[WIDTH_VAR_STATES-1:0] =
                    vars_q[int'(idx_d)*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
            end
            SEND_L: begin
                beatKind = KIND_LVL;
                beatData[WIDTH_LVL_STATES-1:0] =
                    lvls_q[int'(idx_d)*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
            end
            default: begin
                beatKind = KIND_CLAUSE;
                beatData[WIDTH_CLAUSE-1:0] = clause_i;
            end
        endcase
    end

    // Clause read select is a registered one-hot that is only live while
    // the FSM sits in RD_C.
    always_comb begin
        rd_carray_d = '0;
        if (state_d == RD_C) begin
            rd_carray_d = ONE_SEL << idx_d;
        end
    end

    // FSM state, snapshots and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            bin_q       <= '0;
            vars_q      <= '0;
            lvls_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_carray_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bin_q       <= bin_d;
            vars_q      <= vars_d;
            lvls_q      <= lvls_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_carray_q <= rd_carray_d;
        end
    end

    bin_wb_out_reg #(
        .WIDTH_BIN  (WIDTH_BIN_ID),
        .WIDTH_IDX  (WIDTH_IDX),
        .WIDTH_DATA (WIDTH_DATA)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (beatLoad),
        .kind_i  (beatKind),
        .bin_i   (bin_q),
        .idx_i   (idx_d),
        .data_i  (beatData),
        .ready_i (out_ready_i),
        .valid_o (out_valid_o),
        .fire_o  (beatFire),
        .kind_o  (out_kind_o),
        .bin_o   (out_bin_o),
        .idx_o   (out_idx_o),
        .data_o  (out_data_o)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_carray_o = rd_carray_q;

endmodule

// File: tb/tb_bin_writeback.sv
// Bench for bin_writeback: a small engine model answers clause reads, a
// sink drives ready in several patterns, and every accepted beat is checked
// against a beat list built directly from the clause array and the state
// lists as they stood at start.
module tb_bin_writeback;

    localparam int NC = 8;
    localparam int NV = 8;
    localparam int NL = 8;
    localparam int WV = 19;
    localparam int WL = 11;

`ifdef BIN_WB_SKIP_EMPTY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef logic [43:0] beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic [9:0]        bin_id_i;
    logic              busy_o;
    logic              done_o;
    logic [NC-1:0]     rd_carray_o;
    logic [NV*3-1:0]   clause_i;
    logic [WV*NV-1:0]  vars_states_i;
    logic [WL*NL-1:0]  lvl_states_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [1:0]        out_kind_o;
    logic [9:0]        out_bin_o;
    logic [7:0]        out_idx_o;
    logic [23:0]       out_data_o;

    logic [23:0]       cmem [NC];
    logic [23:0]       pendingClause;
    int                readyMode;
    beat_t             expQ[$];
    beat_t             gotQ[$];
    int                doneCount;
    bit                prevStall;
    beat_t             heldBeat;
    int                checks;
    int                failures;

    bin_writeback dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .bin_id_i      (bin_id_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .rd_carray_o   (rd_carray_o),
        .clause_i      (clause_i),
        .vars_states_i (vars_states_i),
        .lvl_states_i  (lvl_states_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_kind_o    (out_kind_o),
        .out_bin_o     (out_bin_o),
        .out_idx_o     (out_idx_o),
        .out_data_o    (out_data_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic beat_t mkBeat(input logic [1:0] kind, input logic [9:0] bin,
                                     input int idx, input logic [23:0] data);
        return {kind, bin, 8'(idx), data};
    endfunction

    function automatic beat_t curBeat();
        return {out_kind_o, out_bin_o, out_idx_o, out_data_o};
    endfunction

    function automatic logic [63:0] packOuts();
        return {9'd0, busy_o, done_o, rd_carray_o, out_valid_o, out_kind_o,
                out_bin_o, out_idx_o, out_data_o};
    endfunction

    // Engine clause array: a read selected during one cycle is answered on
    // clause_i throughout the following cycle.
    always @(negedge clk) begin
        pendingClause = '0;
        for (int c = 0; c < NC; c++) begin
            if (rd_carray_o[c]) pendingClause = pendingClause | cmem[c];
        end
    end

    always @(posedge clk) begin
        #1;
        clause_i = pendingClause;
    end

    // Sink ready pattern: tied high, toggling, or random.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = ~out_ready_i;
            default: out_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    // Stream monitor: records accepted beats, counts done pulses, checks
    // that a stalled beat stays valid and unchanged, and that the clause
    // select is never more than one-hot.
    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stallValid", out_valid_o, 1);
                checkOutput("stallHold", curBeat(), heldBeat);
            end
            checkOutput("rdOneHot", $onehot0(rd_carray_o), 1);
            if (out_valid_o && out_ready_i) gotQ.push_back(curBeat());
            if (done_o) doneCount++;
            prevStall = out_valid_o && !out_ready_i;
            heldBeat  = curBeat();
        end
    end

    // Expected stream from the clause array and the lists seen at start.
    task automatic buildExpected(input logic [9:0] bin, output int expLat);
        expQ.delete();
        expLat = NV + NL + 1;
        for (int c = 0; c < NC; c++) begin
            if (SKIP && cmem[c] == 24'd0) begin
                expLat += 2;
            end else begin
                expQ.push_back(mkBeat(2'd0, bin, c, cmem[c]));
                expLat += 3;
            end
        end
        for (int v = 0; v < NV; v++)
            expQ.push_back(mkBeat(2'd1, bin, v, 24'(vars_states_i[v*WV +: WV])));
        for (int l = 0; l < NL; l++)
            expQ.push_back(mkBeat(2'd2, bin, l, 24'(lvl_states_i[l*WL +: WL])));
    endtask

    task automatic scrambleEngine();
        for (int v = 0; v < NV; v++) vars_states_i[v*WV +: WV] = WV'($urandom);
        for (int l = 0; l < NL; l++) lvl_states_i[l*WL +: WL] = WL'($urandom);
    endtask

    task automatic loadBin2();
        for (int c = 0; c < NC; c++) cmem[c] = 24'($urandom) | 24'h000200;
        cmem[0] = 24'h000042;
    endtask

    task automatic loadBin1();
        for (int c = 0; c < NC; c++) cmem[c] = (c < 3) ? (24'($urandom) | 24'h1) : 24'd0;
    endtask

    // One complete unload: start pulse, engine lists changed right after
    // the snapshot edge, optional extra start mid-stream, then checks of
    // latency, done behaviour and the full beat list.
    task automatic applyStimulus(input logic [9:0] bin, input int mode, input bit extraStart);
        int  cycles;
        int  expLat;
        bit  seen;
        int  n;
        readyMode = mode;
        @(posedge clk);
        #1;
        buildExpected(bin, expLat);
        gotQ.delete();
        doneCount = 0;
        bin_id_i  = bin;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        bin_id_i = 10'($urandom);
        scrambleEngine();
        vars_states_i[3*WV +: WV] = '0;
        if (extraStart) begin
            fork
                begin
                    repeat (10) @(posedge clk);
                    #1 start_i = 1'b1;
                    @(posedge clk);
                    #1 start_i = 1'b0;
                end
            join_none
        end
        cycles = 1;
        seen   = 1'b0;
        n      = 0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            if (n == 0) checkOutput("busyHigh", busy_o, 1);
            if (done_o) seen = 1'b1;
            else cycles++;
            n++;
        end
        checkOutput("doneSeen", seen, 1);
        if (seen) begin
            checkOutput("doneBusyLow", busy_o, 0);
            checkOutput("doneValidLow", out_valid_o, 0);
            if (mode == 0) checkOutput("latency", cycles, expLat);
        end
        repeat (4) @(negedge clk);
        checkOutput("doneCount", doneCount, 1);
        checkOutput("beatCount", gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
            checkOutput($sformatf("beat%0d", i), gotQ[i], expQ[i]);
    endtask

    // Reset asserted while the fifth clause beat is on the bus.
    task automatic resetMidStream();
        bit hit;
        readyMode = 0;
        loadBin2();
        @(posedge clk);
        #1 bin_id_i = 10'd3; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clk);
            if (out_valid_o && out_kind_o == 2'd0 && out_idx_o == 8'd4) hit = 1'b1;
        end
        checkOutput("rstReach", hit, 1);
        #2 rst = 1'b1;
        #1 checkOutput("rstMidOuts", packOuts(), 0);
        @(negedge clk);
        checkOutput("rstHoldOuts", packOuts(), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rstRelOuts", packOuts(), 0);
    endtask

    // Test sequence.
    initial begin
        int lat;
        checks        = 0;
        failures      = 0;
        readyMode     = 0;
        rst           = 1'b1;
        start_i       = 1'b0;
        bin_id_i      = '0;
        clause_i      = '0;
        out_ready_i   = 1'b1;
        pendingClause = '0;
        doneCount     = 0;
        prevStall     = 1'b0;
        heldBeat      = '0;
        vars_states_i = '0;
        lvl_states_i  = '0;
        for (int c = 0; c < NC; c++) cmem[c] = '0;

        repeat (3) @(negedge clk);
        checkOutput("resetOuts", packOuts(), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("idleOuts", packOuts(), 0);

        $display("[TB] bin2, ready high, var3 snapshot");
        loadBin2();
        scrambleEngine();
        vars_states_i[3*WV +: WV] = 19'h5A5A3;
        applyStimulus(10'd5, 0, 1'b0);
        if (gotQ.size() > 0)
            checkOutput("firstBeat", gotQ[0], mkBeat(2'd0, 10'd5, 0, 24'h000042));
        if (gotQ.size() > NC + 3)
            checkOutput("var3Snap", gotQ[NC+3], mkBeat(2'd1, 10'd5, 3, 24'h05A5A3));

        $display("[TB] bin2, ready toggling");
        scrambleEngine();
        applyStimulus(10'd7, 1, 1'b0);

        $display("[TB] reset mid stream then fresh unload");
        resetMidStream();
        scrambleEngine();
        applyStimulus(10'd9, 0, 1'b0);

        $display("[TB] extra start while busy");
        scrambleEngine();
        applyStimulus(10'd11, 0, 1'b1);

        $display("[TB] bin1 with empty clauses");
        loadBin1();
        scrambleEngine();
        applyStimulus(10'd1, 0, 1'b0);
        buildExpected(10'd1, lat);
        checkOutput("bin1Beats", gotQ.size(), SKIP ? 19 : 24);

        $display("[TB] randomized unloads");
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NC; c++)
                cmem[c] = ($urandom_range(0, 9) < 3) ? 24'd0 : (24'($urandom) | 24'h1);
            scrambleEngine();
            applyStimulus(10'($urandom), (r % 2 == 0) ? 2 : 0, r == 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
